// File: rtl/msb_locator_if.sv
// Request/result bundle for the leading-one locator.
// The master issues start/value/mode; the slave returns busy and the latched result.
interface msb_locator_if #(
  parameter int WIDTH = 24,
  parameter int LOC_W = 5
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             mode;
  logic             busy;
  logic [LOC_W-1:0] location;
  logic             zero;
  logic             location_valid;

  modport master (
    output start, value, mode,
    input  busy, location, zero, location_valid
  );

  modport slave (
    input  start, value, mode,
    output busy, location, zero, location_valid
  );
endinterface

// File: rtl/msb_locator.sv
// Multi-cycle leading-one locator: drops the fraction, scans the integer part
// CHUNK bits per cycle from the top, and returns the raw index or the sqrt seed.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; last result (if any) held on the outputs
// S_SCAN | examining chunk k_q of the captured integer part
module msb_locator #(
  parameter int WIDTH     = 24,
  parameter int FRAC_BITS = 4,
  parameter int CHUNK     = 4
) (
  input  logic           clk,
  input  logic           rst_,
  msb_locator_if.slave   bus
);

  localparam int INT_W  = WIDTH - FRAC_BITS;
  localparam int NCHUNK = (INT_W + CHUNK - 1) / CHUNK;
  localparam int LOC_W  = (INT_W > 1) ? $clog2(INT_W) : 1;
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [0:0]     S_IDLE = 1'b0;
  localparam logic [0:0]     S_SCAN = 1'b1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);

  logic [0:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic [INT_W-1:0] int_q, int_d;
  logic             mode_q, mode_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [LOC_W-1:0] location_q, location_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic [PAD_W-1:0] padded;
  logic [CHUNK-1:0] chunk;
  logic             found;
  int               hit_pos;
  logic [LOC_W-1:0] hit_idx;
  logic [LOC_W:0]   seed_w;
  logic [LOC_W-1:0] loc_sel;

  // Fraction bits are discarded by design; fold the whole operand here.
  logic unused_value;
  assign unused_value = ^bus.value;

  // Chunks are aligned to the LSB, so any padding sits above bit INT_W-1.
  always_comb begin
    padded             = '0;
    padded[INT_W-1:0]  = int_q;
    chunk              = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (k_q == K_W'(c)) begin
        chunk = padded[PAD_W-1-c*CHUNK -: CHUNK];
      end
    end
    found   = |chunk;
    hit_pos = 0;
    for (int j = 0; j < CHUNK; j++) begin
      if (chunk[j]) begin
        hit_pos = j;
      end
    end
    hit_idx = LOC_W'((NCHUNK - 1 - int'(k_q)) * CHUNK + hit_pos);
    seed_w  = ({1'b0, hit_idx} + (LOC_W+1)'(1)) >> 1;
    loc_sel = mode_q ? seed_w[LOC_W-1:0] : hit_idx;
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    int_d      = int_q;
    mode_d     = mode_q;
    k_d        = k_q;
    location_d = location_q;
    zero_d     = zero_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          int_d   = bus.value[WIDTH-1:FRAC_BITS];
          mode_d  = bus.mode;
          k_d     = '0;
          valid_d = 1'b0;
          zero_d  = 1'b0;
          state_d = S_SCAN;
          busy_d  = 1'b1;
        end
      end
      S_SCAN: begin
        if (found) begin
          location_d = loc_sel;
          zero_d     = 1'b0;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end else if (k_q == K_LAST) begin
          location_d = '0;
          zero_d     = 1'b1;
          valid_d    = 1'b1;
          state_d    = S_IDLE;
          busy_d     = 1'b0;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      int_q      <= '0;
      mode_q     <= 1'b0;
      k_q        <= '0;
      location_q <= '0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      int_q      <= int_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      location_q <= location_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.location       = location_q;
  assign bus.zero           = zero_q;
  assign bus.location_valid = valid_q;

endmodule

// File: tb/tb_msb_locator.sv
// Directed bench for msb_locator in two configurations, scoreboard-checked.
module tb_msb_locator;

  logic clk;
  logic rst_;

  msb_locator_if #(.WIDTH(24), .LOC_W(5)) if_a ();
  msb_locator_if #(.WIDTH(12), .LOC_W(3)) if_b ();

  msb_locator #(.WIDTH(24), .FRAC_BITS(4), .CHUNK(4)) dut_a (
    .clk (clk),
    .rst_(rst_),
    .bus (if_a)
  );

  msb_locator #(.WIDTH(12), .FRAC_BITS(4), .CHUNK(3)) dut_b (
    .clk (clk),
    .rst_(rst_),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int loc;
    int zf;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;
  int   last_loc[2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_valid(input int sel);
    return sel ? int'(if_b.location_valid) : int'(if_a.location_valid);
  endfunction
  function automatic int get_busy(input int sel);
    return sel ? int'(if_b.busy) : int'(if_a.busy);
  endfunction
  function automatic int get_loc(input int sel);
    return sel ? int'(if_b.location) : int'(if_a.location);
  endfunction
  function automatic int get_zero(input int sel);
    return sel ? int'(if_b.zero) : int'(if_a.zero);
  endfunction

  // Reference: highest set integer bit, chunks aligned to the LSB.
  function automatic exp_t model(input int sel, input logic [31:0] v, input logic m);
    exp_t        e;
    int          int_w, chunk, nch, pad, hi;
    logic [31:0] iv;
    int_w = sel ? 8 : 20;
    chunk = sel ? 3 : 4;
    nch   = (int_w + chunk - 1) / chunk;
    pad   = nch * chunk;
    iv    = v >> 4;
    hi    = -1;
    for (int b = 0; b < int_w; b++) begin
      if (iv[b]) hi = b;
    end
    if (hi < 0) begin
      e.loc = 0;
      e.zf  = 1;
      e.lat = nch;
    end else begin
      e.loc = m ? (hi + 1) / 2 : hi;
      e.zf  = 0;
      e.lat = (pad - 1 - hi) / chunk + 1;
    end
    return e;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [31:0] v, input logic m);
    if (sel != 0) begin
      if_b.start = st;
      if_b.value = v[11:0];
      if_b.mode  = m;
    end else begin
      if_a.start = st;
      if_a.value = v[23:0];
      if_a.mode  = m;
    end
  endtask

  task automatic run(input int sel, input logic [31:0] v, input logic m,
                     input int intrude, input string tag);
    exp_t e;
    int   n;
    int   busy_cnt;
    sb.push_back(model(sel, v, m));
    drive(sel, 1'b1, v, m);
    @(posedge clk); #1;
    if (intrude != 0) drive(sel, 1'b1, 32'h10, 1'b0);
    else              drive(sel, 1'b0, 32'h0, 1'b0);
    chk({tag, "_accept_valid"}, get_valid(sel), 0);
    chk({tag, "_accept_busy"}, get_busy(sel), 1);
    chk({tag, "_loc_held"}, get_loc(sel), last_loc[sel]);
    n = 0;
    busy_cnt = 1;
    while (n < 20) begin
      @(posedge clk); #1;
      drive(sel, 1'b0, 32'h0, 1'b0);
      n++;
      if (get_valid(sel) != 0) break;
      if (get_busy(sel) != 0) busy_cnt++;
    end
    e = sb.pop_front();
    if (get_valid(sel) == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_busy_cycles"}, busy_cnt, e.lat);
      chk({tag, "_location"}, get_loc(sel), e.loc);
      chk({tag, "_zero"}, get_zero(sel), e.zf);
      chk({tag, "_busy_done"}, get_busy(sel), 0);
    end
    @(posedge clk); #1;
    chk({tag, "_hold_valid"}, get_valid(sel), 1);
    chk({tag, "_hold_loc"}, get_loc(sel), e.loc);
    chk({tag, "_hold_busy"}, get_busy(sel), 0);
    last_loc[sel] = e.loc;
  endtask

  initial begin
    last_loc[0] = 0;
    last_loc[1] = 0;
    rst_ = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d_busy", s), get_busy(s), 0);
      chk($sformatf("rst%0d_valid", s), get_valid(s), 0);
      chk($sformatf("rst%0d_loc", s), get_loc(s), 0);
      chk($sformatf("rst%0d_zero", s), get_zero(s), 0);
    end
    rst_ = 1'b1;
    @(posedge clk); #1;

    run(0, 32'h800000, 1'b0, 0, "top_raw");
    run(0, 32'h800000, 1'b1, 0, "top_seed");
    run(0, 32'h001000, 1'b1, 0, "bit8_seed");
    run(0, 32'h001000, 1'b0, 0, "bit8_raw");

    // Abort a zero-operand scan with reset at E0+2.
    drive(0, 1'b1, 32'h0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_ = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", get_busy(0), 0);
    chk("midrst_valid", get_valid(0), 0);
    chk("midrst_loc", get_loc(0), 0);
    chk("midrst_zero", get_zero(0), 0);
    drive(0, 1'b1, 32'h800000, 1'b0);
    @(posedge clk); #1;
    chk("rst_start_busy", get_busy(0), 0);
    chk("rst_start_valid", get_valid(0), 0);
    drive(0, 1'b0, 32'h0, 1'b0);
    rst_ = 1'b1;
    last_loc[0] = 0;
    last_loc[1] = 0;
    @(posedge clk); #1;

    run(0, 32'h800000, 1'b0, 0, "post_rst");
    run(0, 32'h000010, 1'b0, 0, "bit0_raw");
    run(0, 32'h000010, 1'b1, 0, "bit0_seed");
    run(0, 32'h00000F, 1'b0, 0, "frac_only");
    run(0, 32'h800000, 1'b0, 1, "intrude");
    run(0, 32'h000010, 1'b0, 0, "after_intrude");
    run(0, 32'h000000, 1'b1, 0, "zero_seed");
    run(0, 32'h0A5F3C, 1'b0, 0, "mixed_raw");
    run(0, 32'h0A5F3C, 1'b1, 0, "mixed_seed");

    run(1, 32'h0F0, 1'b0, 0, "pad_raw");
    run(1, 32'h0F0, 1'b1, 0, "pad_seed");
    run(1, 32'hFF0, 1'b0, 0, "pad_top");
    run(1, 32'hFF0, 1'b1, 0, "pad_top_seed");
    run(1, 32'h00F, 1'b0, 0, "pad_frac");

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
